// File: rtl/mest_result_collector.sv
// Collects processor results into a FIFO for a downstream consumer, tracking
// run totals, dropped results and zero-flag consistency across a collection run.
module mest_result_collector #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_valid_result,
    input  logic              i_carry,
    input  logic              i_zero_flag,
    input  logic              i_all_done,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [DATA_W+1:0] o_rd_data,
    output logic [AW:0]       o_count,
    output logic [15:0]       o_total,
    output logic              o_overflow,
    output logic              o_zero_err,
    output logic              o_done
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [15:0]       total_q, total_d;
    logic              overflow_q, overflow_d;
    logic              zero_err_q, zero_err_d;
    logic              done_q, done_d;
    logic              push, pop, full, start_ok;
    logic [DATA_W+1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        zero_err_d = zero_err_q;

        start_ok = i_start && (state_q == IDLE || state_q == DONE);
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && i_rd_ready;
        // A full FIFO still accepts a result when the head leaves on the same edge.
        push     = (state_q == COLLECT) && i_valid_result && (!full || pop);

        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            total_d  = total_q + 16'd1;
            if (i_zero_flag != (i_result == '0))
                zero_err_d = 1'b1;
        end
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        if ((state_q == COLLECT) && i_valid_result && full && !pop)
            overflow_d = 1'b1;

        case (state_q)
            COLLECT: if (i_all_done) state_d = DRAIN;
            DRAIN:   if (count_d == '0) state_d = DONE;
            default: ;
        endcase

        if (start_ok) begin
            state_d    = COLLECT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            total_d    = '0;
            overflow_d = 1'b0;
            zero_err_d = 1'b0;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
            zero_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
            zero_err_q <= zero_err_d;
            done_q     <= done_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= {i_carry, i_zero_flag, i_result};
    end

    assign o_rd_valid = (count_q != '0);
    assign o_rd_data  = mem[rd_ptr_q];
    assign o_count    = count_q;
    assign o_total    = total_q;
    assign o_overflow = overflow_q;
    assign o_zero_err = zero_err_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_mest_result_collector.sv
// Directed bench for mest_result_collector: stimulus queues expected FIFO
// entries, a negedge monitor pops and compares every entry the consumer takes.
module tb_mest_result_collector;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_valid_result, i_carry, i_zero_flag;
    logic        i_all_done, i_rd_ready;
    logic [7:0]  i_result;
    logic        o_rd_valid, o_overflow, o_zero_err, o_done;
    logic [9:0]  o_rd_data;
    logic [4:0]  o_count;
    logic [15:0] o_total;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];

    mest_result_collector #(.DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_result(i_result),
        .i_valid_result(i_valid_result), .i_carry(i_carry), .i_zero_flag(i_zero_flag),
        .i_all_done(i_all_done), .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid),
        .o_rd_data(o_rd_data), .o_count(o_count), .o_total(o_total),
        .o_overflow(o_overflow), .o_zero_err(o_zero_err), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: each consumed head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (o_rd_valid && i_rd_ready && !i_reset) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_data_unexpected: got 0x%03h, expected no entry", o_rd_data);
            end else begin
                logic [9:0] exp_v;
                exp_v = sb.pop_front();
                if (o_rd_data !== exp_v) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%03h, expected 0x%03h", o_rd_data, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push(input logic [7:0] r, input logic c, input logic z, input bit accepted);
        i_result = r; i_carry = c; i_zero_flag = z; i_valid_result = 1'b1;
        if (accepted) sb.push_back({c, z, r});
        tick();
        i_valid_result = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        i_rd_ready = 1'b1;
        while (o_count != 0 && n < 100) begin
            tick();
            n++;
        end
        i_rd_ready = 1'b0;
        chk({name, "_drained"}, o_count, 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic finish_run(input string name);
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
        drain(name);
        tick();
        chk({name, "_done"}, o_done, 1);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 0; i_valid_result = 0; i_carry = 0;
        i_zero_flag = 0; i_all_done = 0; i_rd_ready = 0; i_result = 0;
        tick();
        chk("rst_count", o_count, 0);
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_total", o_total, 0);
        chk("rst_flags", {o_overflow, o_zero_err, o_done}, 0);
        i_reset = 1'b0;
        tick();

        // Basic ordered collection with consumer always ready
        start_run();
        i_rd_ready = 1'b1;
        push(8'd5,   1'b0, 1'b0, 1);
        push(8'd0,   1'b0, 1'b1, 1);
        push(8'd255, 1'b1, 1'b0, 1);
        tick(); tick();
        chk("basic_total", o_total, 3);
        chk("basic_zero_err", o_zero_err, 0);
        chk("basic_sb_empty", sb.size(), 0);
        finish_run("basic");

        // Overflow: 18 results into a 16-deep FIFO, no consumer
        start_run();
        chk("restart_total", o_total, 0);
        chk("restart_done", o_done, 0);
        for (int i = 1; i <= 18; i++)
            push(8'(i), 1'b0, 1'b0, i <= 16);
        chk("ovf_count", o_count, 16);
        chk("ovf_total", o_total, 16);
        chk("ovf_flag", o_overflow, 1);
        chk("ovf_zero_err", o_zero_err, 0);
        finish_run("ovf");

        // Full FIFO with simultaneous push and pop
        start_run();
        chk("restart_ovf_clear", o_overflow, 0);
        for (int i = 0; i < 16; i++)
            push(8'(8'h40 + i), 1'b1, 1'b0, 1);
        chk("full_count", o_count, 16);
        i_rd_ready = 1'b1;
        push(8'h77, 1'b0, 1'b0, 1);
        i_rd_ready = 1'b0;
        chk("pp_count", o_count, 16);
        chk("pp_overflow", o_overflow, 0);
        chk("pp_total", o_total, 17);
        finish_run("pp");

        // Zero-flag mismatch, then drain sequence and done handshake
        start_run();
        push(8'd0, 1'b0, 1'b0, 1);
        chk("zerr_set", o_zero_err, 1);
        push(8'h11, 1'b1, 1'b0, 1);
        push(8'h22, 1'b0, 1'b0, 1);
        push(8'h00, 1'b0, 1'b1, 1);
        i_all_done = 1'b1;
        tick();
        i_all_done = 1'b0;
        chk("drain_count", o_count, 4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_done_low", o_done, 0);
            i_rd_ready = 1'b1;
            tick();
            i_rd_ready = 1'b0;
        end
        chk("drain_done_high", o_done, 1);
        chk("drain_sb_empty", sb.size(), 0);
        push(8'h99, 1'b0, 1'b0, 0);
        chk("done_ignore_count", o_count, 0);
        chk("done_ignore_total", o_total, 4);
        start_run();
        chk("clear_total", o_total, 0);
        chk("clear_zerr", o_zero_err, 0);
        chk("clear_done", o_done, 0);

        // Asynchronous reset mid-collection with 7 entries queued
        for (int i = 0; i < 7; i++)
            push(8'(8'h60 + i), 1'b0, 1'b0, 1);
        chk("pre_rst_count", o_count, 7);
        #2 i_reset = 1'b1;
        #1;
        chk("async_rst_count", o_count, 0);
        chk("async_rst_valid", o_rd_valid, 0);
        chk("async_rst_total", o_total, 0);
        sb.delete();
        #1 i_reset = 1'b0;
        tick();
        push(8'h33, 1'b0, 1'b0, 0);
        chk("idle_ignore_count", o_count, 0);
        chk("idle_ignore_total", o_total, 0);
        start_run();
        push(8'hA5, 1'b1, 1'b1, 1);
        chk("post_rst_count", o_count, 1);
        finish_run("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mest_result_collector.md
MEST_RESULT_COLLECTOR -- requirements
Module: mest_result_collector

Interface
REQ-001 Parameter DATA_W, default 8, width of the processor result.
REQ-002 Parameter DEPTH, default 16, FIFO entries (power of 2, >=2); AW = log2(DEPTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 i_reset  input  1  asynchronous active-high reset.
REQ-005 i_start  input  1  one-cycle pulse, begins a collection run.
REQ-006 i_result  input  DATA_W  processor result (o_result of mest_pro).
REQ-007 i_valid_result  input  1  result/flags valid this cycle.
REQ-008 i_carry  input  1  carry accompanying result.
REQ-009 i_zero_flag  input  1  zero flag accompanying result.
REQ-010 i_all_done  input  1  processor finished program.
REQ-011 i_rd_ready  input  1  consumer accepts head entry.
REQ-012 o_rd_valid  output  1  head entry available.
REQ-013 o_rd_data  output  DATA_W+2  head entry {carry, zero, result}.
REQ-014 o_count  output  AW+1  current FIFO occupancy.
REQ-015 o_total  output  16  results accepted this run, wraps at 65535->0.
REQ-016 o_overflow  output  1  sticky: a result was dropped because FIFO full.
REQ-017 o_zero_err  output  1  sticky: zero flag disagreed with result==0.
REQ-018 o_done  output  1  run complete and FIFO drained.

Function
REQ-019 FSM states IDLE, COLLECT, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: i_start -> COLLECT; on that edge o_total, o_overflow, o_zero_err clear and FIFO empties.
REQ-021 COLLECT: i_all_done -> DRAIN; DRAIN: FIFO empty (after this cycle's pop) -> DONE; DONE: i_start -> COLLECT (same clears as REQ-020).
REQ-022 Results accepted only in COLLECT; i_valid_result in IDLE/DRAIN/DONE ignored, no counters change.
REQ-023 i_valid_result and i_all_done same cycle in COLLECT: result processed per REQ-024, then DRAIN.
REQ-024 Push: COLLECT & i_valid_result & (not full, or pop same cycle) -> write {i_carry, i_zero_flag, i_result} at tail, o_total+1.
REQ-025 Full, no pop, i_valid_result in COLLECT -> entry dropped, o_overflow set next edge, o_total unchanged.
REQ-026 Pop: o_rd_valid & i_rd_ready -> head advances next edge; i_rd_ready while empty has no effect.
REQ-027 o_rd_valid = (o_count != 0); o_rd_data is the head entry, combinational from storage, stable while not popped.
REQ-028 Simultaneous push and pop: o_count unchanged; empty + push + i_rd_ready: push only (o_rd_valid was 0).
REQ-029 Pointers AW bits, wrap DEPTH-1 -> 0; o_count range 0..DEPTH.
REQ-030 Every accepted result: if i_zero_flag != (i_result == 0), o_zero_err set next edge; dropped results not checked.
REQ-031 o_done = 1 exactly in DONE, held until i_start or reset.
REQ-032 i_start in COLLECT or DRAIN ignored.
REQ-033 Latency: pushed entry visible on o_rd_valid/o_rd_data the cycle after the push edge.

Reset
REQ-034 i_reset asserted at any time, including mid-run: state IDLE, pointers and o_count 0, o_rd_valid 0, o_total 0, o_overflow 0, o_zero_err 0, o_done 0, immediately, without waiting for clk.
REQ-035 FIFO storage contents need no reset; o_rd_data is don't-care while o_rd_valid = 0.

Verification
REQ-036 Start, push 3 results (5/c0/z0, 0/c0/z1, 255/c1/z0), i_rd_ready=1 -> entries read in order 0x005, 0x100, 0x2FF; o_total=3; o_zero_err=0.
REQ-037 DEPTH=16, i_rd_ready=0, 18 valid results -> o_count=16, o_total=16, o_overflow=1; reading returns first 16 in order.
REQ-038 Full FIFO, push and pop same cycle -> o_count stays 16, o_overflow stays 0, new entry at tail.
REQ-039 Result 0 with zero flag 0 -> o_zero_err=1 next cycle, entry still stored and read unchanged.
REQ-040 i_all_done with 4 entries queued -> DRAIN, o_done=0 until 4th pop, then o_done=1; later i_valid_result ignored; i_start clears all and re-enters COLLECT.
REQ-041 i_reset pulse mid-COLLECT with 7 entries -> o_count=0, o_rd_valid=0, o_total=0 before next clk edge; i_valid_result ignored until i_start.
